// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Frame: 2-byte big-endian word count, little-endian payload words, XOR checksum byte.
package mips_boot_pkg;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;
  localparam int LEN_W          = HDR_BYTES * 8;

  // States in which the loader is willing to take a stream byte.
  function automatic logic accepts_bytes(input state_t s);
    return (s == HDR_HI) || (s == HDR_LO) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory / core-control outputs of the boot loader.
// The loader uses the slave view; whoever feeds the stream uses the master view.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 10
) ();

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata,
           core_rst, done, error, words_loaded
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata,
           core_rst, done, error, words_loaded
  );

endinterface

// File: rtl/imem_boot_loader_byte_word_assembler.sv
// Packs payload bytes little-endian into 32-bit words and keeps the running XOR checksum.
// word_valid pulses for one cycle right after the byte that completes a word.
module byte_word_assembler
  import mips_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte_data,
  output logic        o_lane_last,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  csum
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);

  logic [LANE_W-1:0] r_lane;
  logic              r_word_valid;
  logic [7:0]        r_csum;
  logic              w_lane_last;

  assign w_lane_last = (r_lane == LANE_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lane       <= '0;
      r_word_valid <= 1'b0;
      r_csum       <= '0;
    end else begin
      r_word_valid <= i_byte_en && w_lane_last;
      if (i_byte_en) begin
        r_lane <= r_lane + 1'b1;
        r_csum <= r_csum ^ i_byte_data;
      end
    end
  end

  // One byte register per lane; each only loads when the lane counter points at it.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      logic [7:0] r_byte;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_byte <= '0;
        end else if (i_byte_en && (r_lane == LANE_W'(gi))) begin
          r_byte <= i_byte_data;
        end
      end
      assign word[gi*8 +: 8] = r_byte;
    end
  endgenerate

  assign o_lane_last = w_lane_last;
  assign word_valid  = r_word_valid;
  assign csum        = r_csum;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses the program frame, writes instruction memory, and releases
// the core only after every word is written and the checksum matches.
module imem_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int NUM_WORDS = 256
) (
  input  logic               clk,
  input  logic               rst,
  imem_boot_loader_if.slave  bus
);

  state_t            r_state;
  state_t            w_state_next;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  w_len_next;
  logic [LEN_W-1:0]  w_len_hdr;
  logic [ADDR_W:0]   r_widx;
  logic [ADDR_W-1:0] r_addr;
  logic              r_in_ready;
  logic              r_done;
  logic              r_error;
  logic              r_core_rst;

  logic              w_xfer;
  logic              w_byte_en;
  logic              w_lane_last;
  logic              w_word_end;
  logic              w_last_word;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic [7:0]        w_csum;

  assign w_xfer      = bus.in_valid && r_in_ready;
  assign w_byte_en   = w_xfer && (r_state == DATA);
  assign w_word_end  = w_byte_en && w_lane_last;
  assign w_last_word = ((LEN_W'(r_widx) + LEN_W'(1)) == r_len);
  assign w_len_hdr   = {r_len[LEN_W-1:8], bus.in_data};

  byte_word_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .i_byte_en   (w_byte_en),
    .i_byte_data (bus.in_data),
    .o_lane_last (w_lane_last),
    .word_valid  (w_word_valid),
    .word        (w_word),
    .csum        (w_csum)
  );

  always_comb begin
    w_state_next = r_state;
    w_len_next   = r_len;
    case (r_state)
      HDR_HI: begin
        if (w_xfer) begin
          w_len_next   = {bus.in_data, 8'h00};
          w_state_next = HDR_LO;
        end
      end
      HDR_LO: begin
        if (w_xfer) begin
          w_len_next = w_len_hdr;
          if (w_len_hdr > LEN_W'(NUM_WORDS)) begin
            w_state_next = ERR;
          end else if (w_len_hdr == '0) begin
            w_state_next = CSUM;
          end else begin
            w_state_next = DATA;
          end
        end
      end
      DATA: begin
        if (w_word_end && w_last_word) begin
          w_state_next = CSUM;
        end
      end
      CSUM: begin
        if (w_xfer) begin
          w_state_next = (bus.in_data == w_csum) ? DONE : ERR;
        end
      end
      DONE:    w_state_next = DONE;
      ERR:     w_state_next = ERR;
      default: w_state_next = ERR;
    endcase
  end

  // Status outputs are registered from the next state so they change on the
  // first cycle of the new state (core_rst falls one cycle after the checksum).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= HDR_HI;
      r_len      <= '0;
      r_widx     <= '0;
      r_addr     <= '0;
      r_in_ready <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_core_rst <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_len      <= w_len_next;
      r_in_ready <= accepts_bytes(w_state_next);
      r_done     <= (w_state_next == DONE);
      r_error    <= (w_state_next == ERR);
      r_core_rst <= (w_state_next != DONE);
      if (w_word_end) begin
        r_addr <= r_widx[ADDR_W-1:0];
        r_widx <= r_widx + 1'b1;
      end
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.imem_we      = w_word_valid;
  assign bus.imem_addr    = r_addr;
  assign bus.imem_wdata   = w_word;
  assign bus.core_rst     = r_core_rst;
  assign bus.done         = r_done;
  assign bus.error        = r_error;
  assign bus.words_loaded = r_widx;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: the driver pushes expected writes and
// frame outcomes as bytes are accepted; a negedge monitor pops and compares them.
module tb_imem_boot_loader;
  import mips_boot_pkg::*;

  localparam int ADDR_W    = 10;
  localparam int NUM_WORDS = 256;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    bit done;
    bit err;
    int words;
    int cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  wr_t         exp_wr[$];
  res_t        exp_res[$];
  logic [31:0] pay_q[$];
  logic [7:0]  frame_q[$];
  int          cur_len;
  bit          cur_ok;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe and the first terminal status are matched
  // against what the driver predicted.
  bit   term_seen = 1'b0;
  logic prev_we   = 1'b0;
  always @(negedge clk) begin : monitor
    wr_t  e;
    res_t r;
    if (rst !== 1'b1) begin
      term_seen = 1'b0;
    end else begin
      if (bus.imem_we === 1'b1) begin
        check("we_single_pulse", prev_we, 0);
        if (exp_wr.size() == 0) begin
          check("unexpected_write", bus.imem_addr, 64'hFFFF);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", bus.imem_addr, e.addr);
          check("wr_data", bus.imem_wdata, e.data);
          check("wr_cycle", cyc, e.cyc);
          $display("[TB] write addr=%0d data=%08h", bus.imem_addr, bus.imem_wdata);
        end
      end
      if (!term_seen && (bus.done === 1'b1 || bus.error === 1'b1)) begin
        term_seen = 1'b1;
        if (exp_res.size() == 0) begin
          check("unexpected_terminal", {bus.done, bus.error}, 0);
        end else begin
          r = exp_res.pop_front();
          check("term_flags", {bus.done, bus.error, bus.core_rst}, {r.done, r.err, !r.done});
          check("term_words", bus.words_loaded, r.words);
          check("term_cycle", cyc, r.cyc);
          check("term_in_ready", bus.in_ready, 0);
          $display("[TB] frame end done=%0b error=%0b words=%0d", bus.done, bus.error,
                   bus.words_loaded);
        end
      end else if (!term_seen) begin
        check("core_held", bus.core_rst, 1);
      end
    end
    prev_we = bus.imem_we;
  end

  task automatic check_reset_vals();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_we", bus.imem_we, 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_wdata", bus.imem_wdata, 0);
    check("rst_words", bus.words_loaded, 0);
    check("rst_done_err", {bus.done, bus.error}, 0);
    check("rst_core_rst", bus.core_rst, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic fill_random(input int n);
    pay_q.delete();
    repeat (n) pay_q.push_back($urandom);
  endtask

  // Reference frame: header, little-endian words, XOR of payload bytes.
  // csum_override < 0 sends the correct checksum, otherwise that byte.
  task automatic build_frame(input int len, input int csum_override);
    logic [7:0]  x;
    logic [7:0]  sent;
    logic [31:0] wd;
    frame_q.delete();
    cur_len = len;
    frame_q.push_back(8'(len >> 8));
    frame_q.push_back(8'(len));
    if (len <= NUM_WORDS) begin
      x = 8'h00;
      for (int w = 0; w < len; w++) begin
        wd = pay_q[w];
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
          frame_q.push_back(wd[8*b +: 8]);
          x = x ^ wd[8*b +: 8];
        end
      end
      sent = (csum_override < 0) ? x : 8'(csum_override);
      frame_q.push_back(sent);
      cur_ok = (sent == x);
    end else begin
      cur_ok = 1'b0;
    end
    $display("[TB] frame len=%0d bytes=%0d csum_ok=%0b", len, frame_q.size(), cur_ok);
  endtask

  task automatic send_bytes(input int gap_pct, input int n_send);
    int   idx;
    int   guard;
    int   pos;
    bit   v;
    bit   xfer;
    wr_t  w;
    res_t r;
    idx   = 0;
    guard = 0;
    while (idx < n_send && guard < 20000) begin
      @(negedge clk);
      guard++;
      v = ($urandom_range(99) >= gap_pct);
      bus.in_valid = v;
      bus.in_data  = v ? frame_q[idx] : 8'($urandom);
      xfer = v && (bus.in_ready === 1'b1);
      if (xfer) begin
        pos = idx - HDR_BYTES;
        if (cur_len <= NUM_WORDS && pos >= 0 && pos < BYTES_PER_WORD * cur_len &&
            (pos % BYTES_PER_WORD) == BYTES_PER_WORD - 1) begin
          w.addr = pos / BYTES_PER_WORD;
          w.data = pay_q[w.addr];
          w.cyc  = cyc + 1;
          exp_wr.push_back(w);
        end
        if (idx == frame_q.size() - 1 && n_send == frame_q.size()) begin
          r.done  = cur_ok;
          r.err   = !cur_ok;
          r.words = (cur_len <= NUM_WORDS) ? cur_len : 0;
          r.cyc   = cyc + 1;
          exp_res.push_back(r);
        end
        idx++;
      end
    end
    check("stream_progress", idx, n_send);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_frame();
    repeat (3) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      check("stray_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    check("writes_drained", exp_wr.size(), 0);
    check("result_seen", exp_res.size(), 0);
    do_reset();
  endtask

  task automatic run_frame(input int len, input int csum_override, input int gap_pct);
    build_frame(len, csum_override);
    send_bytes(gap_pct, frame_q.size());
    finish_frame();
  endtask

  initial begin
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b1;

    pay_q = '{32'h20080005, 32'h8C090000};
    run_frame(2, -1, 0);
    pay_q.delete();
    run_frame(0, -1, 0);
    run_frame(257, -1, 0);
    pay_q = '{32'h20080005, 32'h8C090000};
    run_frame(2, 8'hA9, 0);
    run_frame(2, -1, 50);

    // Abort after the 6th payload byte, then reload from scratch.
    build_frame(2, -1);
    send_bytes(0, HDR_BYTES + 6);
    do_reset();
    check("abort_writes_drained", exp_wr.size(), 0);
    run_frame(2, -1, 0);

    fill_random(NUM_WORDS);
    run_frame(NUM_WORDS, -1, 0);
    run_frame(int'($urandom_range(65535, NUM_WORDS + 1)), -1, 0);

    for (int t = 0; t < 10; t++) begin
      fill_random(int'($urandom_range(6)));
      run_frame(pay_q.size(),
                ($urandom_range(3) == 0) ? int'($urandom_range(255)) : -1,
                int'($urandom_range(60)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream stage of the MIPS core. Receives a program image as a byte stream over a valid/ready link and writes it word-by-word into the instruction memory.
- Holds the core in reset until the whole image is written and its checksum has been verified.
- On success it releases the core. On any framing or checksum error it keeps the core in reset and flags the error.

Parameters:
- ADDR_W, 10, width of the instruction-memory word index (imem_addr).
- NUM_WORDS, 256, maximum accepted program length in 32-bit words; must satisfy NUM_WORDS <= 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 immediately forces the reset state.
- in_valid  input  1  a byte is offered on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte; a transfer occurs on a clock edge where in_valid=1 and in_ready=1.
- imem_we  output  1  one-cycle write strobe to the instruction memory.
- imem_addr  output  ADDR_W  word index of the write.
- imem_wdata  output  32  write data.
- core_rst  output  1  active-high reset to the MIPS core.
- done  output  1  image loaded and verified.
- error  output  1  load aborted.
- words_loaded  output  ADDR_W+1  count of words written so far.

Behaviour:
- Reset values (rst=0, asynchronous):
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, words_loaded=0, done=0, error=0.
  - core_rst=1, state=HDR_HI, byte lane=0, checksum accumulator=0.
- Frame format:
  - Two header bytes give the word count L, big-endian (high byte first).
  - Then L words of 4 bytes each, little-endian (byte 0 = bits 7:0).
  - Then one checksum byte equal to the XOR of all payload bytes; header bytes are excluded.
- States:
  - HDR_HI: in_ready=1. On transfer, latch L[15:8]; go to HDR_LO.
  - HDR_LO: in_ready=1. On transfer, latch L[7:0].
    - If L > NUM_WORDS, go to ERR.
    - If L == 0, go to CSUM.
    - Otherwise go to DATA.
  - DATA: in_ready=1. Each transfer places the byte in lane 0..3 of the assembly register and XORs it into the accumulator.
    - On the transfer into lane 3, the next cycle shows imem_we=1, imem_addr = current word index, imem_wdata = assembled word. Lane returns to 0 and the word index increments.
    - words_loaded increments in the same cycle imem_we is high.
    - After word L-1 is accepted, go to CSUM.
  - CSUM: in_ready=1. On transfer, compare the byte with the accumulator.
    - On a match, go to DONE.
    - On a mismatch, go to ERR.
  - DONE: in_ready=0, done=1, core_rst=0; these take effect on the first cycle in DONE.
  - ERR: in_ready=0, error=1, core_rst=1.
  - DONE and ERR are terminal; only rst leaves them.
- Latency and ordering:
  - The write strobe comes exactly 1 cycle after the 4th byte of a word.
  - core_rst deasserts exactly 1 cycle after the accepted checksum byte.
  - The last imem write therefore always completes before core_rst falls.
- Stalls: in_valid=0 for any number of cycles leaves all state, including the partial word, unchanged. imem_we only ever pulses for one cycle.
- Stray input: bytes offered in DONE or ERR are never accepted (in_ready=0).
- Reset mid-operation: asserting rst at any point discards the partial image and returns to the reset state. Already-written memory contents are not cleared; the next load overwrites them.
- Width rules:
  - L is 16 bits; the comparison against NUM_WORDS is unsigned.
  - The word index is ADDR_W bits and never wraps, because L <= NUM_WORDS is enforced.

Decomposition:
- Shared package mips_boot_pkg holds:
  - the state enum (HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR);
  - localparam BYTES_PER_WORD=4;
  - localparam HDR_BYTES=2.
- One natural sub-module, byte_word_assembler: the lane counter, the 32-bit assembly register and the XOR accumulator. It outputs word_valid, word and csum.
- The FSM and the memory interface stay in imem_boot_loader.

Test Plan:
- Nominal load: stream 00 02 | 05 00 08 20 | 00 00 09 8C | A8 with in_valid held high.
  - Expect imem_we at addr 0 with data 0x20080005, then at addr 1 with data 0x8C090000.
  - Expect words_loaded=2, done=1, core_rst=0 one cycle after the A8 byte, and error=0.
- Empty image: stream 00 00 | 00.
  - Expect no imem_we, done=1, core_rst=0.
- Oversize header: stream 01 01 (L=257) with NUM_WORDS=256.
  - Expect error=1 and in_ready=0 the cycle after the second byte, core_rst=1, no writes.
- Bad checksum: nominal stream but send checksum A9.
  - Expect both writes, then error=1, done=0, core_rst=1.
- Backpressure/gaps: nominal stream with in_valid randomly low 50% of cycles.
  - Expect identical writes and data; the partial word is held across gaps; done after A8.
- Reset mid-load: drive rst=0 after the 6th data byte, release it, then send the full nominal stream.
  - Expect immediate core_rst=1 and in_ready=0 during reset, then a fresh load writing addr 0 and addr 1 correctly, ending with done=1.
